// File: rtl/jk_pkg.sv
// Shared types for the J/K drive sequencer.
// Optional checker is enabled by JK_DRV_CHECK_EN.
package jk_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_RESET  = 2'd1,
    OP_SET    = 2'd2,
    OP_TOGGLE = 2'd3
  } jk_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE
  } jk_state_t;

  function automatic logic [1:0] jk_enc(input jk_op_t op);
    logic [1:0] jk;
    jk = 2'b00;
    case (op)
      OP_HOLD:   jk = 2'b00;
      OP_RESET:  jk = 2'b01;
      OP_SET:    jk = 2'b10;
      OP_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_ff.sv
// Plain J/K flip-flop driven by jk_drive_ctrl.
// Deliberately has no reset; its state is unknown until SET/RESET.
module jk_ff (
  input  logic clk,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  // classic J/K next-state behaviour
  always_ff @(posedge clk) begin
    case ({j, k})
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_ref_model.sv
// Expected-q model and sticky mismatch comparator.
// Only instantiated when JK_DRV_CHECK_EN is defined.
module jk_ref_model
  import jk_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   drive,
  input  logic   check,
  input  jk_op_t op,
  input  logic   q,
  input  logic   qbar,
  output logic   exp_q,
  output logic   mismatch
);

  logic exp_vld;

  // track q per drive edge; compare once the model is anchored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q    <= 1'b0;
      exp_vld  <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      if (drive) begin
        case (op)
          OP_SET: begin
            exp_q   <= 1'b1;
            exp_vld <= 1'b1;
          end
          OP_RESET: begin
            exp_q   <= 1'b0;
            exp_vld <= 1'b1;
          end
          OP_TOGGLE: exp_q <= ~exp_q;
          default: ;
        endcase
      end
      if (check && exp_vld &&
          ((q != exp_q) || (qbar == q)))
        mismatch <= 1'b1;
    end
  end

endmodule

// File: rtl/jk_drive_ctrl.sv
// Command sequencer driving jk_ff j/k for N edges.
// Define JK_DRV_CHECK_EN to add exp_q/mismatch checking.
module jk_drive_ctrl
  import jk_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  input  logic             q,
  input  logic             qbar
`ifdef JK_DRV_CHECK_EN
  ,
  output logic             exp_q,
  output logic             mismatch
`endif
);

  jk_state_t        state;
  jk_op_t           op_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_init;

  assign cnt_init = (cmd_len == '0) ? '0
                  : cmd_len - LEN_W'(1);

  // sequencer; ready/busy lag state by a cycle so
  // ready only returns after the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_HOLD;
      cnt       <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= jk_op_t'(cmd_op);
            cnt       <= cnt_init;
            {j, k}    <= jk_enc(jk_op_t'(cmd_op));
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_DRIVE;
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - LEN_W'(1);
          end else begin
            {j, k} <= 2'b00;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JK_DRV_CHECK_EN
  jk_ref_model u_ref (
    .clk      (clk),
    .rst_n    (rst_n),
    .drive    (state == ST_DRIVE),
    .check    (state != ST_DRIVE),
    .op       (op_q),
    .q        (q),
    .qbar     (qbar),
    .exp_q    (exp_q),
    .mismatch (mismatch)
  );
`else
  logic unused_fb;
  assign unused_fb = ^{q, qbar, op_q};
`endif

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Bench for jk_drive_ctrl driving a jk_ff.
// Checker ports are exercised when JK_DRV_CHECK_EN is defined.
module tb_jk_drive_ctrl;

  localparam logic [1:0] HOLD   = 2'd0;
  localparam logic [1:0] RESET  = 2'd1;
  localparam logic [1:0] SET    = 2'd2;
  localparam logic [1:0] TOGGLE = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_len = 8'd0;
  logic       cmd_ready, j, k, busy, done;
  logic       ff_q, ff_qbar, q_in;
  logic       ovr = 1'b0;
`ifdef JK_DRV_CHECK_EN
  logic       exp_q, mismatch;
`endif

  int  checks = 0;
  int  errors = 0;
  bit  q_model = 1'b0;
  bit  q_known = 1'b0;
  bit  exp_mm = 1'b0;
  bit  mm_at_n = 1'b0;

  assign q_in = ovr ? 1'b0 : ff_q;

  always #5 clk = ~clk;

  jk_drive_ctrl #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .q         (q_in),
    .qbar      (ff_qbar)
`ifdef JK_DRV_CHECK_EN
    ,
    .exp_q     (exp_q),
    .mismatch  (mismatch)
`endif
  );

  jk_ff u_ff (
    .clk  (clk),
    .j    (j),
    .k    (k),
    .q    (ff_q),
    .qbar (ff_qbar)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // j/k pattern an op must present to the flop
  function automatic logic [1:0] enc_of(input logic [1:0] op);
    return {op == SET || op == TOGGLE,
            op == RESET || op == TOGGLE};
  endfunction

  // issue one command and check its whole timeline
  task automatic do_cmd(input logic [1:0] op,
                        input logic [7:0] len,
                        input bit hold);
    int n, c, waitc, done_cnt, done_at, ready_at;
    bit jk_ok, busy_ok;
    logic [1:0] enc;
    n = (len == 0) ? 1 : int'(len);
    enc = enc_of(op);
    waitc = 0;
    while (!cmd_ready && waitc < 400) begin
      @(negedge clk);
      waitc++;
    end
    if (!cmd_ready) begin
      check("ready_wait", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_len = len;
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    case (op)
      SET:    begin q_model = 1'b1; q_known = 1'b1; end
      RESET:  begin q_model = 1'b0; q_known = 1'b1; end
      TOGGLE: q_model = q_model ^ n[0];
      default: ;
    endcase
    jk_ok = 1'b1;
    busy_ok = 1'b1;
    done_cnt = 0;
    done_at = -1;
    ready_at = -1;
    c = 0;
    while (c <= n + 3) begin
      if ({j, k} !== ((c < n) ? enc : 2'b00)) jk_ok = 1'b0;
      if (busy !== (c <= n + 1)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
`ifdef JK_DRV_CHECK_EN
      if (c == n) mm_at_n = mismatch;
`endif
      if (cmd_ready === 1'b1) begin
        ready_at = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    check("jk_window", 32'(jk_ok), 32'd1);
    check("busy_window", 32'(busy_ok), 32'd1);
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_at), 32'(n + 1));
    check("ready_cycle", 32'(ready_at), 32'(n + 2));
    if (q_known) begin
      check("q_final", 32'(ff_q), 32'(q_model));
      check("qbar_final", 32'(ff_qbar), 32'(!q_model));
`ifdef JK_DRV_CHECK_EN
      check("exp_q", 32'(exp_q), 32'(q_model));
`endif
    end
`ifdef JK_DRV_CHECK_EN
    check("mismatch", 32'(mismatch), 32'(exp_mm));
`endif
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] len;
    bit         hold;
    bit         eq;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{SET,    8'd1, 1'b0, 1'b1};
    tbl[1] = '{TOGGLE, 8'd5, 1'b0, 1'b0};
    tbl[2] = '{TOGGLE, 8'd4, 1'b0, 1'b0};
    tbl[3] = '{RESET,  8'd0, 1'b0, 1'b0};
    tbl[4] = '{SET,    8'd3, 1'b1, 1'b1};
    tbl[5] = '{HOLD,   8'd2, 1'b1, 1'b1};
    tbl[6] = '{TOGGLE, 8'd1, 1'b1, 1'b0};
    tbl[7] = '{TOGGLE, 8'd7, 1'b0, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_j", 32'(j), 32'd0);
    check("rst_k", 32'(k), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef JK_DRV_CHECK_EN
    check("rst_exp_q", 32'(exp_q), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(cmd_ready), 32'd1);

    // directed table, including held-valid back-to-back
    foreach (tbl[i]) begin
      do_cmd(tbl[i].op, tbl[i].len, tbl[i].hold);
      check("tbl_q", 32'(ff_q), 32'(tbl[i].eq));
    end

    // randomized commands against the bench model
    for (int i = 0; i < 40; i++) begin
      do_cmd(2'($urandom_range(0, 3)),
             8'($urandom_range(0, 12)),
             (i != 39) && ($urandom_range(0, 1) == 1));
    end
    cmd_valid = 1'b0;

`ifdef JK_DRV_CHECK_EN
    // corrupt q seen by the checker after a SET
    do_cmd(RESET, 8'd1, 1'b0);
    ovr = 1'b1;
    exp_mm = 1'b1;
    do_cmd(SET, 8'd2, 1'b0);
    check("mm_before_settle", 32'(mm_at_n), 32'd0);
    ovr = 1'b0;
    do_cmd(TOGGLE, 8'd3, 1'b0);
    do_cmd(SET, 8'd1, 1'b0);
`endif

    // reset mid-way through a long toggle
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = TOGGLE;
    cmd_len = 8'd200;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (50) @(negedge clk);
    check("mid_jk", 32'({j, k}), 32'd3);
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_jk", 32'({j, k}), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    q_known = 1'b0;
    exp_mm = 1'b0;
    #1;
    check("rel_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("rel_ready_high", 32'(cmd_ready), 32'd1);
    check("rel_done", 32'(done), 32'd0);
`ifdef JK_DRV_CHECK_EN
    check("rel_mismatch", 32'(mismatch), 32'd0);
`endif
    repeat (3) @(negedge clk);
    do_cmd(TOGGLE, 8'd3, 1'b0);
    do_cmd(HOLD, 8'd2, 1'b0);
    do_cmd(RESET, 8'd1, 1'b0);
    do_cmd(TOGGLE, 8'd9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
